pipe_datapath: RTL and testbench

Parametrised five-stage (IF/ID, ID/EX, EX/MEM, MEM/WB) integer datapath for the pipelined MIPS core, sitting between the instruction fetch unit and an external data memory. It holds the register file, sign extender, ALU, all stage registers and a hazard/forwarding unit. Unlike the first-generation datapath, it resolves read-after-write hazards internally, either by forwarding with load-use stalls or by full interlock, and reports stalls to fetch.

---
 rtl/pipe_datapath.sv | 167 ++++++++++++++++
 tb/tb_pipe_datapath.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_datapath.sv
// pipe_datapath: five-stage MIPS integer datapath with register file, ALU and hazard unit
// Ports: clk, rst (async, active-high); Instructions with RegDst/RegWr/ALUsrc/ALUcntrl/MemWr/MemToReg
//   from fetch; dmem_addr/dmem_wdata/dmem_we out and dmem_rdata in for the data memory;
//   seOut = ID/EX immediate, reg_Da = EX A operand, stall = hold PC and re-present the instruction.
// Build option: PIPE_DATAPATH_FWD_EN selects forwarding with load-use stalls; otherwise full interlock.
module pipe_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Instructions,
    input  logic             RegDst,
    input  logic             RegWr,
    input  logic             ALUsrc,
    input  logic [1:0]       ALUcntrl,
    input  logic             MemWr,
    input  logic             MemToReg,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic             dmem_we,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] seOut,
    output logic [WIDTH-1:0] reg_Da,
    output logic             stall
);
    typedef struct packed {
        logic [25:0] instr;
        logic        regdst;
        logic        regwr;
        logic        alusrc;
        logic [1:0]  aluc;
        logic        memwr;
        logic        memtoreg;
    } ifid_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] imm;
`ifdef PIPE_DATAPATH_FWD_EN
        logic [4:0]       rs;
        logic [4:0]       rt;
`endif
        logic [4:0]       dest;
        logic             wr;
        logic             alusrc;
        logic [1:0]       aluc;
        logic             memwr;
        logic             memtoreg;
    } idex_t;

    typedef struct packed {
        logic [WIDTH-1:0] alu;
        logic [WIDTH-1:0] wdata;
        logic [4:0]       dest;
        logic             wr;
        logic             memwr;
        logic             memtoreg;
    } exmem_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [4:0]       dest;
        logic             wr;
    } memwb_t;

    ifid_t            ifid_q, ifid_d;
    idex_t            idex_q, idex_d;
    exmem_t           exmem_q, exmem_d;
    memwb_t           memwb_q, memwb_d;
    logic [WIDTH-1:0] rf_q [32];
    logic [WIDTH-1:0] rf_d [32];
    logic [4:0]       rs, rt, rd, dest;
    logic             use_rt;
    logic [WIDTH-1:0] rs_val, rt_val, op_a, op_rt, op_b, alu;
    logic             unused_opcode;

    assign unused_opcode = ^Instructions[31:26];

    // Decode and register read; a write retiring this cycle is bypassed into ID.
    always_comb begin
        rs     = ifid_q.instr[25:21];
        rt     = ifid_q.instr[20:16];
        rd     = ifid_q.instr[15:11];
        dest   = ifid_q.regdst ? rd : rt;
        use_rt = !ifid_q.alusrc || ifid_q.memwr;
        rs_val = (rs == 5'd0) ? '0 : (memwb_q.wr && memwb_q.dest == rs) ? memwb_q.data : rf_q[rs];
        rt_val = (rt == 5'd0) ? '0 : (memwb_q.wr && memwb_q.dest == rt) ? memwb_q.data : rf_q[rt];
    end

    // A valid dest is never r0, so a source of r0 can never match here.
    always_comb begin
`ifdef PIPE_DATAPATH_FWD_EN
        stall = idex_q.memtoreg && idex_q.wr && (idex_q.dest == rs || (use_rt && idex_q.dest == rt));
`else
        stall = (idex_q.wr && (idex_q.dest == rs || (use_rt && idex_q.dest == rt))) ||
                (exmem_q.wr && (exmem_q.dest == rs || (use_rt && exmem_q.dest == rt)));
`endif
    end

    // IF/ID holds on stall while ID/EX takes an all-zero bubble.
    always_comb begin
        ifid_d = stall ? ifid_q : {Instructions[25:0], RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg};
        idex_d = '0;
        if (!stall) begin
            idex_d.a        = rs_val;
            idex_d.b        = rt_val;
            idex_d.imm      = WIDTH'($signed(ifid_q.instr[15:0]));
`ifdef PIPE_DATAPATH_FWD_EN
            idex_d.rs       = rs;
            idex_d.rt       = rt;
`endif
            idex_d.dest     = dest;
            idex_d.wr       = ifid_q.regwr && dest != 5'd0;
            idex_d.alusrc   = ifid_q.alusrc;
            idex_d.aluc     = ifid_q.aluc;
            idex_d.memwr    = ifid_q.memwr;
            idex_d.memtoreg = ifid_q.memtoreg;
        end
    end

    // EX: the younger EX/MEM result wins over MEM/WB when both match.
    always_comb begin
`ifdef PIPE_DATAPATH_FWD_EN
        op_a  = (exmem_q.wr && exmem_q.dest == idex_q.rs) ? exmem_q.alu :
                (memwb_q.wr && memwb_q.dest == idex_q.rs) ? memwb_q.data : idex_q.a;
        op_rt = (exmem_q.wr && exmem_q.dest == idex_q.rt) ? exmem_q.alu :
                (memwb_q.wr && memwb_q.dest == idex_q.rt) ? memwb_q.data : idex_q.b;
`else
        op_a  = idex_q.a;
        op_rt = idex_q.b;
`endif
        op_b    = idex_q.alusrc ? idex_q.imm : op_rt;
        alu     = (idex_q.aluc == 2'b00) ? op_a + op_b :
                  (idex_q.aluc == 2'b01) ? op_a - op_b :
                  (idex_q.aluc == 2'b10) ? op_a & op_b : WIDTH'($signed(op_a) < $signed(op_b));
        exmem_d = {alu, op_rt, idex_q.dest, idex_q.wr, idex_q.memwr, idex_q.memtoreg};
    end

    always_comb begin
        memwb_d = {exmem_q.memtoreg ? dmem_rdata : exmem_q.alu, exmem_q.dest, exmem_q.wr};
        rf_d    = rf_q;
        if (memwb_q.wr) rf_d[memwb_q.dest] = memwb_q.data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            rf_q    <= '{default: '0};
        end else begin
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            rf_q    <= rf_d;
        end
    end

    assign dmem_addr  = exmem_q.alu;
    assign dmem_wdata = exmem_q.wdata;
    assign dmem_we    = exmem_q.memwr;
    assign seOut      = idex_q.imm;
    assign reg_Da     = op_a;
endmodule

// File: tb/tb_pipe_datapath.sv
// tb_pipe_datapath: scoreboard bench; stores are the observed transactions, stalls checked per instruction
module tb_pipe_datapath;
    localparam int W = 32;
`ifdef PIPE_DATAPATH_FWD_EN
    localparam int S2 = 0, SLU = 1, S1 = 0;
`else
    localparam int S2 = 2, SLU = 2, S1 = 1;
`endif
    localparam logic [6:0] C_NOP = 7'b0000000, C_ADDI = 7'b0110000, C_LW = 7'b0110001,
                           C_SW = 7'b0010010, C_ADD = 7'b1100000, C_SUB = 7'b1100100,
                           C_AND = 7'b1101000, C_SLT = 7'b1101100;

    logic          clk = 0, rst = 1;
    logic [31:0]   Instructions;
    logic          RegDst, RegWr, ALUsrc, MemWr, MemToReg;
    logic [1:0]    ALUcntrl;
    logic [W-1:0]  dmem_addr, dmem_wdata, dmem_rdata, seOut, reg_Da;
    logic          dmem_we, stall;

    typedef struct {
        logic [W-1:0] addr;
        logic [W-1:0] data;
        string        tag;
    } exp_t;
    exp_t exp_q[$];

    int    checks = 0, passes = 0;
    int    pend = 0;
    string pend_name = "idle";

    pipe_datapath #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .Instructions(Instructions), .RegDst(RegDst), .RegWr(RegWr),
        .ALUsrc(ALUsrc), .ALUcntrl(ALUcntrl), .MemWr(MemWr), .MemToReg(MemToReg),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
        .seOut(seOut), .reg_Da(reg_Da), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ity(input int rs, input int rt, input logic [15:0] imm);
        return {6'd0, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] rty(input int rs, input int rt, input int rd);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    // Present an instruction until an edge with stall low captures it; ns counts the held cycles,
    // which belong to the instruction already sitting in IF/ID.
    task automatic issue(input logic [31:0] ins, input logic [6:0] c, output int ns);
        Instructions = ins;
        {RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg} = c;
        ns = 0;
        @(negedge clk);
        while (stall && ns < 8) begin
            ns++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    // exp_stall < 0 means the stall count of this instruction is not checked.
    task automatic op(input string name, input logic [31:0] ins, input logic [6:0] c, input int exp_stall);
        int ns;
        issue(ins, c, ns);
        if (pend >= 0) chk({"stall cycles of ", pend_name}, W'(ns), W'(pend));
        pend      = exp_stall;
        pend_name = name;
    endtask

    task automatic st(input string name, input int rt, input int imm, input int rs,
                      input logic [W-1:0] ea, input logic [W-1:0] ed, input int es);
        exp_q.push_back('{ea, ed, name});
        op(name, ity(rs, rt, 16'(imm)), C_SW, es);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && dmem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected store: addr %h data %h with no store expected", dmem_addr, dmem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, " addr"}, dmem_addr, e.addr);
                chk({e.tag, " data"}, dmem_wdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        Instructions = '0;
        {RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg} = C_NOP;
        dmem_rdata = 32'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", W'(stall), 0);
        chk("reset seOut", seOut, 0);
        chk("reset reg_Da", reg_Da, 0);
        chk("reset dmem_addr", dmem_addr, 0);
        chk("reset dmem_wdata", dmem_wdata, 0);
        chk("reset dmem_we", W'(dmem_we), 0);
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle stall", W'(stall), 0);
        end
        @(posedge clk);
        #1;
        for (int r = 1; r < 32; r++) st($sformatf("probe r%0d", r), r, r * 4, 0, W'(r * 4), 0, 0);
        op("addi r1,r0,5", ity(0, 1, 16'd5), C_ADDI, 0);
        op("add r2,r1,r1", rty(1, 1, 2), C_ADD, S2);
        st("sw r0,0(r2)", 0, 0, 2, 10, 0, S2);
        op("lw r3,0(r0)", ity(0, 3, 16'd0), C_LW, 0);
        op("add r4,r3,r3", rty(3, 3, 4), C_ADD, SLU);
        st("sw r4,0x20(r0)", 4, 32'h20, 0, 32'h20, 32'h2468, S2);
        op("addi r5,r0,7", ity(0, 5, 16'd7), C_ADDI, 0);
        st("sw r5,4(r0)", 5, 4, 0, 4, 7, S2);
        op("addi r0,r0,9", ity(0, 0, 16'd9), C_ADDI, 0);
        op("add r6,r0,r0", rty(0, 0, 6), C_ADD, 0);
        st("sw r6,0x30(r0)", 6, 32'h30, 0, 32'h30, 0, S2);
        op("addi r7,r0,1", ity(0, 7, 16'd1), C_ADDI, 0);
        op("addi r7,r0,2", ity(0, 7, 16'd2), C_ADDI, 0);
        op("add r8,r7,r7", rty(7, 7, 8), C_ADD, S2);
        st("sw r8,0x40(r0)", 8, 32'h40, 0, 32'h40, 4, S2);
        op("addi r9,r0,3", ity(0, 9, 16'd3), C_ADDI, 0);
        op("nop", '0, C_NOP, 0);
        op("add r10,r9,r0", rty(9, 0, 10), C_ADD, S1);
        st("sw r10,0x44(r0)", 10, 32'h44, 0, 32'h44, 3, S2);
        op("addi r11,r0,-3", ity(0, 11, 16'hFFFD), C_ADDI, 0);
        op("nop", '0, C_NOP, 0);
        chk("seOut of addi -3", seOut, 32'hFFFF_FFFD);
        op("slt r12,r11,r1", rty(11, 1, 12), C_SLT, -1);
        op("sub r13,r1,r11", rty(1, 11, 13), C_SUB, -1);
        op("and r14,r5,r1", rty(5, 1, 14), C_AND, -1);
        st("sw r12,0x50(r0)", 12, 32'h50, 0, 32'h50, 1, -1);
        st("sw r13,0x54(r0)", 13, 32'h54, 0, 32'h54, 8, -1);
        st("sw r14,0x58(r0)", 14, 32'h58, 0, 32'h58, 5, -1);
        op("addi r16,r0,0x11", ity(0, 16, 16'h11), C_ADDI, 0);
        op("addi r17,r16,1", ity(16, 17, 16'd1), C_ADDI, S2);
        op("nop", '0, C_NOP, 0);
        chk("reg_Da for addi r17", reg_Da, 32'h11);
        for (int i = 0; i < 4; i++) op("nop", '0, C_NOP, 0);
        op("sw r5,0x60(r0) killed", ity(0, 5, 16'h60), C_SW, 0);
        Instructions = '0;
        {RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg} = C_NOP;
        @(posedge clk);
        #1;
        chk("killed store in ID/EX seOut", seOut, 32'h60);
        rst = 1;
        #1;
        chk("mid-reset dmem_we", W'(dmem_we), 0);
        chk("mid-reset seOut", seOut, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held-reset dmem_we", W'(dmem_we), 0);
        end
        @(posedge clk);
        #1 rst = 0;
        pend = 0;
        pend_name = "post-reset";
        for (int i = 0; i < 3; i++) op("nop", '0, C_NOP, 0);
        st("probe r5 after reset", 5, 32'h70, 0, 32'h70, 0, 0);
        st("probe r1 after reset", 1, 32'h74, 0, 32'h74, 0, 0);
        for (int i = 0; i < 4; i++) op("nop", '0, C_NOP, 0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard drained", W'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
